carfield_regbus_decode_responder: RTL and testbench



---
 rtl/carfield_regbus_pkg.sv | 49 ++++
 rtl/carfield_regbus_addr_match.sv | 62 ++++++
 rtl/carfield_regbus_decode_responder.sv | 207 ++++++++++++++++++++
 tb/tb_carfield_regbus_decode_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_regbus_pkg.sv
// ---------------------------------------------------------------------------
// carfield_regbus_pkg
// Shared definitions for the Carfield RegBus decode/responder slice:
//   - state_e            : responder FSM states (IDLE / FWD / RESP)
//   - ERR_RDATA_DEFAULT  : read data returned with locally generated errors
//   - TIMEOUT_CNT_WIDTH  : hold-off counter width for the default timeout
//   - tmo_cnt_width()    : counter width for an arbitrary timeout value
//   - regbus_req_t/rsp_t : RegBus request/response bundles (default widths)
// ---------------------------------------------------------------------------
package carfield_regbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;
    localparam int unsigned TIMEOUT_CNT_WIDTH      = $clog2(TIMEOUT_CYCLES_DEFAULT);

    localparam int unsigned REGBUS_AW = 48;
    localparam int unsigned REGBUS_DW = 32;
    localparam int unsigned REGBUS_SW = REGBUS_DW / 8;

    typedef struct packed {
        logic                 valid;
        logic [REGBUS_AW-1:0] addr;
        logic                 write;
        logic [REGBUS_DW-1:0] wdata;
        logic [REGBUS_SW-1:0] wstrb;
    } regbus_req_t;

    typedef struct packed {
        logic                 ready;
        logic [REGBUS_DW-1:0] rdata;
        logic                 error;
    } regbus_rsp_t;

    // The counter only has to reach cycles-1, so $clog2 is enough; keep at
    // least one bit so a degenerate value still yields a legal vector.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/carfield_regbus_addr_match.sv
// ---------------------------------------------------------------------------
// carfield_regbus_addr_match
// Purely combinational address decoder. Each target owns a window
// [base, base+size); a window takes part only when enabled and non-empty.
// Overlapping windows resolve to the lowest target index.
// Ports:
//   addr_i        : address to decode
//   tgt_base_i    : packed per-target window bases
//   tgt_size_i    : packed per-target window sizes
//   tgt_enable_i  : per-target window enables
//   match_o       : some window covers addr_i
//   sel_o         : index of the winning window (0 when no match)
// ---------------------------------------------------------------------------
module carfield_regbus_addr_match
    import carfield_regbus_pkg::*;
#(
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned NumTargets = 4,
    parameter int unsigned SelWidth   = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
    input  logic [AddrWidth-1:0]            addr_i,
    input  logic [NumTargets*AddrWidth-1:0] tgt_base_i,
    input  logic [NumTargets*AddrWidth-1:0] tgt_size_i,
    input  logic [NumTargets-1:0]           tgt_enable_i,
    output logic                            match_o,
    output logic [SelWidth-1:0]             sel_o
);

    logic [NumTargets-1:0] w_hit;

    for (genvar g = 0; g < NumTargets; g++) begin : gen_window
        logic [AddrWidth-1:0] w_base;
        logic [AddrWidth-1:0] w_size;
        logic [AddrWidth:0]   w_limit;

        assign w_base  = tgt_base_i[g*AddrWidth +: AddrWidth];
        assign w_size  = tgt_size_i[g*AddrWidth +: AddrWidth];

        // One extra bit so a window ending at the top of the address space
        // does not wrap its limit back to zero.
        assign w_limit = {1'b0, w_base} + {1'b0, w_size};

        assign w_hit[g] = tgt_enable_i[g]
                        && (w_size != '0)
                        && (addr_i >= w_base)
                        && ({1'b0, addr_i} < w_limit);
    end

    // Scan from the highest index down so the lowest hit is the last one
    // written and therefore wins.
    always_comb begin
        match_o = 1'b0;
        sel_o   = '0;
        for (int i = NumTargets - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                match_o = 1'b1;
                sel_o   = SelWidth'(i);
            end
        end
    end

endmodule

// File: rtl/carfield_regbus_decode_responder.sv
// ---------------------------------------------------------------------------
// carfield_regbus_decode_responder
// Responder end of the Carfield RegBus configuration map. Takes one upstream
// request at a time, decodes it against per-target windows, forwards it to
// the selected target and returns that target's response. Unmapped/disabled
// addresses and targets that never answer get a local error response so the
// host can never stall.
// Ports:
//   clk_i, rst_ni                   : clock, asynchronous active-low reset
//   req_valid_i/addr/write/wdata/wstrb : upstream request (held until rsp)
//   rsp_ready_o/rdata/error         : one-cycle upstream response
//   tgt_base_i/size_i/enable_i      : per-target decode windows
//   tgt_valid_o                     : one-hot forwarded valid
//   tgt_addr/write/wdata/wstrb_o    : captured request, shared by targets
//   tgt_ready_i/rdata_i/error_i     : per-target responses
//   timeout_o                       : pulse with a timeout response
//   timeout_cnt_o                   : saturating number of timeouts
// ---------------------------------------------------------------------------
module carfield_regbus_decode_responder
    import carfield_regbus_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumTargets    = 4,
    parameter int unsigned          TimeoutCycles = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [DataWidth-1:0] ErrRdata      = DataWidth'(ERR_RDATA_DEFAULT)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic                            req_valid_i,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic                            req_write_i,
    input  logic [DataWidth-1:0]            req_wdata_i,
    input  logic [DataWidth/8-1:0]          req_wstrb_i,

    output logic                            rsp_ready_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            rsp_error_o,

    input  logic [NumTargets*AddrWidth-1:0] tgt_base_i,
    input  logic [NumTargets*AddrWidth-1:0] tgt_size_i,
    input  logic [NumTargets-1:0]           tgt_enable_i,

    output logic [NumTargets-1:0]           tgt_valid_o,
    output logic [AddrWidth-1:0]            tgt_addr_o,
    output logic                            tgt_write_o,
    output logic [DataWidth-1:0]            tgt_wdata_o,
    output logic [DataWidth/8-1:0]          tgt_wstrb_o,
    input  logic [NumTargets-1:0]           tgt_ready_i,
    input  logic [NumTargets*DataWidth-1:0] tgt_rdata_i,
    input  logic [NumTargets-1:0]           tgt_error_i,

    output logic                            timeout_o,
    output logic [7:0]                      timeout_cnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned SelWidth  = (NumTargets > 1) ? $clog2(NumTargets) : 1;
    localparam int unsigned TmoWidth  = tmo_cnt_width(TimeoutCycles);

    state_e                  r_state;
    logic [SelWidth-1:0]     r_sel;
    logic [AddrWidth-1:0]    r_addr;
    logic                    r_write;
    logic [DataWidth-1:0]    r_wdata;
    logic [StrbWidth-1:0]    r_wstrb;
    logic [NumTargets-1:0]   r_tgtValid;
    logic [DataWidth-1:0]    r_rdata;
    logic                    r_error;
    logic                    r_timeout;
    logic                    r_rspValid;
    logic [TmoWidth-1:0]     r_tmoCnt;
    logic [7:0]              r_timeoutCnt;

    logic                    w_match;
    logic [SelWidth-1:0]     w_sel;
    logic [NumTargets-1:0]   w_selOnehot;
    logic                    w_tgtReady;
    logic [DataWidth-1:0]    w_tgtRdata;
    logic                    w_tgtError;
    logic                    w_tmoLast;

    // Decode the live upstream address so an unmapped request can be
    // answered in the very next cycle.
    carfield_regbus_addr_match #(
        .AddrWidth  (AddrWidth),
        .NumTargets (NumTargets),
        .SelWidth   (SelWidth)
    ) u_addr_match (
        .addr_i       (req_addr_i),
        .tgt_base_i   (tgt_base_i),
        .tgt_size_i   (tgt_size_i),
        .tgt_enable_i (tgt_enable_i),
        .match_o      (w_match),
        .sel_o        (w_sel)
    );

    always_comb begin
        w_selOnehot        = '0;
        w_selOnehot[w_sel] = 1'b1;
    end

    // Only the latched target's handshake is looked at; the others are
    // ignored even if they raise ready.
    assign w_tgtReady = tgt_ready_i[r_sel];
    assign w_tgtRdata = tgt_rdata_i[r_sel*DataWidth +: DataWidth];
    assign w_tgtError = tgt_error_i[r_sel];

    // Counter holds the index of the current FWD cycle, so hitting
    // TimeoutCycles-1 without ready means TimeoutCycles valid cycles elapsed.
    assign w_tmoLast = (r_tmoCnt == TmoWidth'(TimeoutCycles - 1));

    // Single FSM: captures the request in IDLE, waits for the target in FWD
    // and presents the registered response for exactly one RESP cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_tgtValid   <= '0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
            r_timeout    <= 1'b0;
            r_rspValid   <= 1'b0;
            r_tmoCnt     <= '0;
            r_timeoutCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rspValid <= 1'b0;
                    if (req_valid_i) begin
                        r_addr    <= req_addr_i;
                        r_write   <= req_write_i;
                        r_wdata   <= req_wdata_i;
                        r_wstrb   <= req_wstrb_i;
                        r_timeout <= 1'b0;
                        r_tmoCnt  <= '0;
                        if (w_match) begin
                            r_sel      <= w_sel;
                            r_tgtValid <= w_selOnehot;
                            r_state    <= ST_FWD;
                        end else begin
                            r_rdata    <= ErrRdata;
                            r_error    <= 1'b1;
                            r_rspValid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end

                ST_FWD: begin
                    if (w_tgtReady) begin
                        r_rdata    <= w_tgtRdata;
                        r_error    <= w_tgtError;
                        r_tmoCnt   <= '0;
                        r_tgtValid <= '0;
                        r_rspValid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else if (w_tmoLast) begin
                        r_rdata    <= ErrRdata;
                        r_error    <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_tmoCnt   <= '0;
                        r_tgtValid <= '0;
                        r_rspValid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    r_rspValid <= 1'b0;
                    if (r_timeout && (r_timeoutCnt != 8'hFF)) begin
                        r_timeoutCnt <= r_timeoutCnt + 8'd1;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_tgtValid <= '0;
                    r_rspValid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tgt_valid_o   = r_tgtValid;
    assign tgt_addr_o    = r_addr;
    assign tgt_write_o   = r_write;
    assign tgt_wdata_o   = r_wdata;
    assign tgt_wstrb_o   = r_wstrb;

    // Read data is only meaningful for a read response; everything else
    // sees zeros so stale target data never leaks upstream.
    assign rsp_ready_o   = r_rspValid;
    assign rsp_rdata_o   = (r_rspValid && !r_write) ? r_rdata : '0;
    assign rsp_error_o   = r_rspValid & r_error;
    assign timeout_o     = r_rspValid & r_timeout;
    assign timeout_cnt_o = r_timeoutCnt;

endmodule

// File: tb/tb_carfield_regbus_decode_responder.sv
// ---------------------------------------------------------------------------
// tb_carfield_regbus_decode_responder
// Self-checking bench: a driver issues requests and plays the targets, an
// address-map model predicts each response and pushes it into a queue, and
// an independent monitor pops and compares whenever rsp_ready_o is seen.
// ---------------------------------------------------------------------------
module tb_carfield_regbus_decode_responder;

    localparam int unsigned AW  = 48;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned NT  = 4;
    localparam int unsigned T   = 16;
    localparam logic [31:0] ERR = 32'hBADCAB1E;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic [AW-1:0]     req_addr_i;
    logic              req_write_i;
    logic [DW-1:0]     req_wdata_i;
    logic [SW-1:0]     req_wstrb_i;
    logic              rsp_ready_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_error_o;
    logic [NT*AW-1:0]  tgt_base_i;
    logic [NT*AW-1:0]  tgt_size_i;
    logic [NT-1:0]     tgt_enable_i;
    logic [NT-1:0]     tgt_valid_o;
    logic [AW-1:0]     tgt_addr_o;
    logic              tgt_write_o;
    logic [DW-1:0]     tgt_wdata_o;
    logic [SW-1:0]     tgt_wstrb_o;
    logic [NT-1:0]     tgt_ready_i;
    logic [NT*DW-1:0]  tgt_rdata_i;
    logic [NT-1:0]     tgt_error_i;
    logic              timeout_o;
    logic [7:0]        timeout_cnt_o;

    carfield_regbus_decode_responder #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .NumTargets    (NT),
        .TimeoutCycles (T),
        .ErrRdata      (ERR)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_addr_i    (req_addr_i),
        .req_write_i   (req_write_i),
        .req_wdata_i   (req_wdata_i),
        .req_wstrb_i   (req_wstrb_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_error_o   (rsp_error_o),
        .tgt_base_i    (tgt_base_i),
        .tgt_size_i    (tgt_size_i),
        .tgt_enable_i  (tgt_enable_i),
        .tgt_valid_o   (tgt_valid_o),
        .tgt_addr_o    (tgt_addr_o),
        .tgt_write_o   (tgt_write_o),
        .tgt_wdata_o   (tgt_wdata_o),
        .tgt_wstrb_o   (tgt_wstrb_o),
        .tgt_ready_i   (tgt_ready_i),
        .tgt_rdata_i   (tgt_rdata_i),
        .tgt_error_i   (tgt_error_i),
        .timeout_o     (timeout_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          startCyc;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          modelTmo = 0;
    logic [63:0] cfgBase [NT];
    logic [63:0] cfgSize [NT];
    bit          cfgEn   [NT];

    always @(posedge clk_i) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address map reference: first enabled, non-empty window containing the
    // address, evaluated with 64-bit arithmetic so nothing can wrap.
    function automatic int modelTarget(input logic [AW-1:0] a);
        logic [63:0] addr64;
        addr64 = {16'h0, a};
        for (int i = 0; i < NT; i++) begin
            if (cfgEn[i] && cfgSize[i] != 0 && addr64 >= cfgBase[i]
                && addr64 < cfgBase[i] + cfgSize[i])
                return i;
        end
        return -1;
    endfunction

    task automatic setWindow(input int i, input logic [AW-1:0] base, input logic [AW-1:0] size, input bit en);
        cfgBase[i] = {16'h0, base};
        cfgSize[i] = {16'h0, size};
        cfgEn[i]   = en;
        tgt_base_i[i*AW +: AW] = base;
        tgt_size_i[i*AW +: AW] = size;
        tgt_enable_i[i]        = en;
    endtask

    // Monitor: every response strobe consumes exactly one prediction.
    always @(negedge clk_i) begin
        if (rst_ni && rsp_ready_o) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpectedResponse: got rsp_ready_o=1, expected no response (t=%0t)", $time);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rspRdata", rsp_rdata_o, e.rdata);
                checkOutput("rspError", rsp_error_o, e.err);
                checkOutput("timeoutPulse", timeout_o, e.tmo);
                checkOutput("latency", cyc - e.startCyc, e.lat);
            end
        end
    end

    // One full transaction: predict, issue, play the targets, then check
    // the idle state and the timeout counter afterwards.
    task automatic applyStimulus(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                                 input logic [SW-1:0] wstrb, input int waitCycles,
                                 input logic [DW-1:0] trdata, input bit terr);
        int         tgt;
        int         expValid;
        int         validCnt;
        bit         done;
        logic [3:0] expOh;
        exp_t       e;

        tgt   = modelTarget(addr);
        expOh = (tgt >= 0) ? 4'(1 << tgt) : 4'b0;
        e.tmo = 1'b0;
        if (tgt < 0) begin
            e.rdata  = wr ? 32'h0 : ERR;
            e.err    = 1'b1;
            e.lat    = 1;
            expValid = 0;
        end else if (waitCycles >= int'(T)) begin
            e.rdata  = wr ? 32'h0 : ERR;
            e.err    = 1'b1;
            e.tmo    = 1'b1;
            e.lat    = 1 + T;
            expValid = T;
            if (modelTmo < 255) modelTmo++;
        end else begin
            e.rdata  = wr ? 32'h0 : trdata;
            e.err    = terr;
            e.lat    = 2 + waitCycles;
            expValid = waitCycles + 1;
        end

        @(negedge clk_i);
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        req_valid_i = 1'b1;
        e.startCyc  = cyc;
        expQ.push_back(e);

        validCnt = 0;
        done     = 1'b0;
        for (int k = 0; k < int'(T) + 8 && !done; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                req_addr_i  = {$urandom(), $urandom()};
                req_write_i = ~wr;
                req_wdata_i = $urandom();
                req_wstrb_i = ~wstrb;
            end
            tgt_ready_i = 4'($urandom()) & ~expOh;
            tgt_rdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            tgt_error_i = 4'($urandom());
            if (rsp_ready_o) begin
                done = 1'b1;
            end else if (tgt_valid_o != '0) begin
                validCnt++;
                checkOutput("tgtValid", tgt_valid_o, expOh);
                if (validCnt == 1) begin
                    checkOutput("tgtAddr", tgt_addr_o, addr);
                    checkOutput("tgtWrite", tgt_write_o, wr);
                    checkOutput("tgtWdata", tgt_wdata_o, wdata);
                    checkOutput("tgtWstrb", tgt_wstrb_o, wstrb);
                end
                if (tgt >= 0 && validCnt == waitCycles + 1) begin
                    tgt_ready_i[tgt]           = 1'b1;
                    tgt_rdata_i[tgt*DW +: DW]  = trdata;
                    tgt_error_i[tgt]           = terr;
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL rspWait: got no response, expected one within %0d cycles", T + 8);
        end
        checkOutput("validCycles", validCnt, expValid);
        req_valid_i = 1'b0;
        tgt_ready_i = '0;

        @(negedge clk_i);
        checkOutput("timeoutCnt", timeout_cnt_o, modelTmo);
        checkOutput("idleRspReady", rsp_ready_o, 0);
        checkOutput("idleRdata", rsp_rdata_o, 0);
    endtask

    task automatic configA();
        setWindow(0, 48'h2000_0000, 48'h1_0000, 1'b1);
        setWindow(1, 48'h2002_0000, 48'h1000, 1'b1);
        setWindow(2, 48'h0, 48'h0, 1'b1);
        setWindow(3, 48'h3000_0000, 48'h100, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        int            ti;

        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_write_i  = 1'b0;
        req_wdata_i  = '0;
        req_wstrb_i  = '0;
        tgt_base_i   = '0;
        tgt_size_i   = '0;
        tgt_enable_i = '0;
        tgt_ready_i  = '0;
        tgt_rdata_i  = '0;
        tgt_error_i  = '0;
        configA();

        repeat (3) @(negedge clk_i);
        checkOutput("resetRspReady", rsp_ready_o, 0);
        checkOutput("resetTgtValid", tgt_valid_o, 0);
        checkOutput("resetTimeoutCnt", timeout_cnt_o, 0);
        checkOutput("resetRspError", rsp_error_o, 0);
        checkOutput("resetTgtAddr", tgt_addr_o, 0);
        rst_ni = 1'b1;

        $display("[TB] directed: forward, unmapped, timeout, empty/disabled windows");
        applyStimulus(48'h2002_0010, 1'b0, 32'h0, 4'hF, 3, 32'h0000_1234, 1'b0);
        applyStimulus(48'h2003_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(48'h2000_0040, 1'b0, 32'h0, 4'hF, 1000, 32'h0, 1'b0);
        applyStimulus(48'h0, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(48'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(48'h2002_0020, 1'b0, 32'h0, 4'hF, T - 1, 32'hCAFE_0001, 1'b1);

        $display("[TB] directed: overlap, window edges, top of address space, strobed write");
        setWindow(1, 48'h2000_9000, 48'h1000, 1'b1);
        setWindow(2, 48'h4000_0000, 48'h800, 1'b1);
        setWindow(3, 48'hFFFF_FFFF_F000, 48'h1000, 1'b1);
        applyStimulus(48'h2000_9000, 1'b0, 32'h0, 4'hF, 0, 32'h1111_0000, 1'b0);
        applyStimulus(48'h4000_07FF, 1'b0, 32'h0, 4'hF, 1, 32'h2222_0000, 1'b0);
        applyStimulus(48'h4000_0800, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        applyStimulus(48'hFFFF_FFFF_FFFF, 1'b0, 32'h0, 4'hF, 2, 32'h3333_0000, 1'b0);
        applyStimulus(48'h4000_0004, 1'b1, 32'hA5A5_5A5A, 4'b0101, 0, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] randomized windows and traffic");
        for (int r = 0; r < 80; r++) begin
            if (r % 10 == 0) begin
                for (int i = 0; i < NT; i++) begin
                    logic [AW-1:0] sz;
                    case ($urandom_range(0, 3))
                        0:       sz = 48'h0;
                        1:       sz = 48'h100;
                        2:       sz = 48'h1000;
                        default: sz = 48'h2000;
                    endcase
                    setWindow(i, 48'h2000_0000 + 48'($urandom_range(0, 15)) * 48'h800, sz,
                              $urandom_range(0, 4) != 0);
                end
            end
            ti = $urandom_range(0, NT - 1);
            case ($urandom_range(0, 5))
                0:       a = cfgBase[ti][AW-1:0];
                1:       a = cfgBase[ti][AW-1:0] + cfgSize[ti][AW-1:0] - 48'h1;
                2:       a = cfgBase[ti][AW-1:0] + cfgSize[ti][AW-1:0];
                3:       a = cfgBase[ti][AW-1:0] - 48'h1;
                4:       a = cfgBase[ti][AW-1:0] + ((cfgSize[ti] != 0) ? 48'($urandom()) % cfgSize[ti][AW-1:0] : 48'h0);
                default: a = 48'h2000_0000 + 48'($urandom_range(0, 16'hFFFF));
            endcase
            applyStimulus(a, 1'($urandom()), $urandom(), 4'($urandom()),
                          $urandom_range(0, T + 1), $urandom(), 1'($urandom()));
        end

        $display("[TB] asynchronous reset during forward");
        configA();
        @(negedge clk_i);
        req_addr_i  = 48'h2002_0010;
        req_write_i = 1'b0;
        req_wstrb_i = 4'hF;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("fwdBeforeReset", tgt_valid_o, 4'b0010);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("asyncResetTgtValid", tgt_valid_o, 0);
        checkOutput("asyncResetRspReady", rsp_ready_o, 0);
        checkOutput("asyncResetTimeoutCnt", timeout_cnt_o, 0);
        req_valid_i = 1'b0;
        modelTmo    = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(48'h2002_0010, 1'b0, 32'h0, 4'hF, 3, 32'h0000_1234, 1'b0);

        repeat (2) @(negedge clk_i);
        checkOutput("pendingExpectations", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
